// File: rtl/iter_sequencer.sv
// iter_sequencer: global barrier and iteration controller for the PageRank
// engine. Releases the ants once per iteration, gates the ant/NoC enable,
// launches the top-10 sorter after MAX_ITER releases and reports completion.
// Optional watchdog: define ITER_TIMEOUT_EN to abort a stalled iteration
// into SORT and raise a sticky timeout_err.
module iter_sequencer #(
  parameter int NUM_ANTS       = 4,
  parameter int MAX_ITER       = 40,
  parameter int ITER_W         = 13,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_ANTS-1:0] ant_sync,
  input  logic                sort_done,
  output logic                run_en,
  output logic                sync_go,
  output logic                sort_start,
  output logic                sort_en,
  output logic [ITER_W-1:0]   iter_count,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  typedef enum logic [2:0] {IDLE, RUN, SYNC, SORT, DONE} state_t;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER);

  state_t              state;
  logic [NUM_ANTS-1:0] armed;
  logic                met;
  logic                start_ok;
  logic [ITER_W-1:0]   iter_next;

  // An ant only counts toward the barrier after it has been seen low since the
  // previous release, so a level held across sync_go is not counted twice.
  assign met       = &(armed & ant_sync);
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign iter_next = iter_count + ITER_W'(1);

  // Status outputs are decoded from the state register only.
  assign run_en  = (state == RUN) || (state == SYNC);
  assign sync_go = (state == SYNC);
  assign sort_en = (state == SORT) || (state == DONE);
  assign busy    = (state == RUN) || (state == SYNC) || (state == SORT);
  assign done    = (state == DONE);

  // Per-ant arming: re-armed when an ant drops its sync after a release.
  always_ff @(posedge clk) begin
    if (reset || start_ok) armed <= '1;
    else if (state == SYNC) armed <= '0;
    else armed <= armed | ~ant_sync;
  end

`ifdef ITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd;
  logic            wd_hit;

  assign wd_hit = (state == RUN) && !met && (wd == WD_LAST);

  // Watchdog: counts RUN cycles of the current iteration; the error is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else if (start_ok) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == SYNC) wd <= '0;
      else if (state == RUN) wd <= wd + WD_W'(1);
      if (wd_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Main sequencer; sort_start is a registered pulse on entry to SORT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iter_count <= '0;
      sort_start <= 1'b0;
    end else begin
      sort_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            iter_count <= '0;
          end
        end
        RUN: begin
          if (met) begin
            state <= SYNC;
          end
`ifdef ITER_TIMEOUT_EN
          else if (wd_hit) begin
            state      <= SORT;
            sort_start <= 1'b1;
          end
`endif
        end
        SYNC: begin
          iter_count <= iter_next;
          if (iter_next == LAST_ITER) begin
            state      <= SORT;
            sort_start <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        SORT: begin
          if (sort_done) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_sequencer.sv
// Bench for iter_sequencer: directed scenarios plus a randomized barrier run
// compared against a per-ant "seen low since last release" model.
module tb_iter_sequencer;

  localparam int ITER_W = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, sort_done = 1'b0;
  logic [3:0] ant = 4'h0;
  logic run_en, sync_go, sort_start, sort_en, busy, done, timeout_err;
  logic [ITER_W-1:0] iter_count;

  logic start1 = 1'b0, sort_done1 = 1'b0;
  logic [3:0] ant1 = 4'h0;
  logic run_en1, sync_go1, sort_start1, sort_en1, busy1, done1, timeout_err1;
  logic [ITER_W-1:0] iter_count1;

  int n_checks = 0;
  int n_fail = 0;

  iter_sequencer #(.NUM_ANTS(4), .MAX_ITER(40), .ITER_W(ITER_W), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .ant_sync(ant), .sort_done(sort_done),
    .run_en(run_en), .sync_go(sync_go), .sort_start(sort_start), .sort_en(sort_en),
    .iter_count(iter_count), .busy(busy), .done(done), .timeout_err(timeout_err));

  iter_sequencer #(.NUM_ANTS(4), .MAX_ITER(1), .ITER_W(ITER_W), .TIMEOUT_CYCLES(100)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ant_sync(ant1), .sort_done(sort_done1),
    .run_en(run_en1), .sync_go(sync_go1), .sort_start(sort_start1), .sort_en(sort_en1),
    .iter_count(iter_count1), .busy(busy1), .done(done1), .timeout_err(timeout_err1));

  always #5 clk = ~clk;

  wire [6:0] outs  = {run_en, sync_go, sort_start, sort_en, busy, done, timeout_err};
  wire [6:0] outs1 = {run_en1, sync_go1, sort_start1, sort_en1, busy1, done1, timeout_err1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one genuine barrier (drop, raise, drop) taking 3 cycles.
  task automatic barrier();
    ant = 4'h0; step();
    ant = 4'hF; step();
    ant = 4'h0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (outs !== 7'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected 0000000", outs); end
    n_checks++; if (iter_count !== '0) begin n_fail++; $display("FAIL reset_iter: got %0d expected 0", iter_count); end
    n_checks++; if (outs1 !== 7'b0) begin n_fail++; $display("FAIL reset_outs1: got %b expected 0000000", outs1); end
  endtask

  task automatic test_full_run();
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if ({run_en, busy, sync_go} !== 3'b110) begin n_fail++; $display("FAIL start_latency: got %b expected 110", {run_en, busy, sync_go}); end
    for (int it = 0; it < 40; it++) begin
      ant = 4'h0;
      for (int w = 0; w < 5; w++) begin
        step();
        n_checks++; if (sync_go !== 1'b0) begin n_fail++; $display("FAIL full_idle_go it=%0d: got %b expected 0", it, sync_go); end
      end
      ant = 4'hF; step();
      n_checks++; if (sync_go !== 1'b1 || iter_count !== ITER_W'(it)) begin n_fail++; $display("FAIL full_go it=%0d: got go=%b cnt=%0d expected go=1 cnt=%0d", it, sync_go, iter_count, it); end
      ant = 4'h0; step();
      if (it < 39) begin
        n_checks++; if ({sync_go, run_en} !== 2'b01 || iter_count !== ITER_W'(it + 1)) begin n_fail++; $display("FAIL full_after it=%0d: got go/run=%b cnt=%0d expected 01 cnt=%0d", it, {sync_go, run_en}, iter_count, it + 1); end
      end else begin
        n_checks++; if ({sort_start, run_en, sort_en, busy, sync_go} !== 5'b10110 || iter_count !== ITER_W'(40)) begin n_fail++; $display("FAIL full_sort_entry: got %b cnt=%0d expected 10110 cnt=40", {sort_start, run_en, sort_en, busy, sync_go}, iter_count); end
      end
    end
    step();
    n_checks++; if ({sort_start, sort_en, busy} !== 3'b011) begin n_fail++; $display("FAIL sort_pulse_once: got %b expected 011", {sort_start, sort_en, busy}); end
    repeat (8) step();
    sort_done = 1'b1; step(); sort_done = 1'b0;
    n_checks++; if ({done, busy, sort_en} !== 3'b101) begin n_fail++; $display("FAIL full_done: got %b expected 101", {done, busy, sort_en}); end
    repeat (3) step();
    n_checks++; if (outs !== 7'b0001010 || iter_count !== ITER_W'(40)) begin n_fail++; $display("FAIL done_hold: got %b cnt=%0d expected 0001010 cnt=40", outs, iter_count); end
  endtask

  task automatic test_random_barrier();
    logic [3:0] fresh, s;
    logic go, ngo;
    int cnt;
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if (iter_count !== '0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL restart_from_done: got cnt=%0d busy=%b done=%b expected 0 1 0", iter_count, busy, done); end
    fresh = 4'hF; go = 1'b0; cnt = 0;
    for (int c = 0; c < 60; c++) begin
      for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 3) != 0);
      ant = s;
      if (go) begin
        fresh = 4'h0; cnt++; ngo = 1'b0;
      end else begin
        ngo = &(fresh & s);
        fresh = fresh | ~s;
      end
      go = ngo;
      step();
      n_checks++; if (sync_go !== go || iter_count !== ITER_W'(cnt) || run_en !== 1'b1) begin n_fail++; $display("FAIL random c=%0d: got go=%b cnt=%0d run=%b expected go=%b cnt=%0d run=1", c, sync_go, iter_count, run_en, go, cnt); end
    end
  endtask

  task automatic test_stale_sync();
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1; ant = 4'h0; step(); start = 1'b0;
    ant = 4'hF; step();
    n_checks++; if (sync_go !== 1'b1) begin n_fail++; $display("FAIL stale_first_go: got %b expected 1", sync_go); end
    ant = 4'h7; step(); step();
    n_checks++; if (sync_go !== 1'b0 || iter_count !== ITER_W'(1)) begin n_fail++; $display("FAIL stale_after: got go=%b cnt=%0d expected 0 1", sync_go, iter_count); end
    ant = 4'hF;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (sync_go !== 1'b0) begin n_fail++; $display("FAIL stale_hold k=%0d: got %b expected 0", k, sync_go); end
    end
    ant = 4'h8; step();
    n_checks++; if (sync_go !== 1'b0) begin n_fail++; $display("FAIL stale_rearm: got %b expected 0", sync_go); end
    ant = 4'hF; step();
    n_checks++; if (sync_go !== 1'b1) begin n_fail++; $display("FAIL stale_release: got %b expected 1", sync_go); end
    ant = 4'h0; step();
    n_checks++; if (iter_count !== ITER_W'(2)) begin n_fail++; $display("FAIL stale_count: got %0d expected 2", iter_count); end
  endtask

  task automatic test_start_ignored();
    repeat (4) barrier();
    ant = 4'h0; step();
    ant = 4'hF; step(); step();
    n_checks++; if (iter_count !== ITER_W'(7)) begin n_fail++; $display("FAIL ign_pre_count: got %0d expected 7", iter_count); end
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if ({busy, run_en, done} !== 3'b110 || iter_count !== ITER_W'(7)) begin n_fail++; $display("FAIL ign_start: got %b cnt=%0d expected 110 cnt=7", {busy, run_en, done}, iter_count); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (sync_go !== 1'b0) begin n_fail++; $display("FAIL ign_no_rearm k=%0d: got %b expected 0", k, sync_go); end
    end
    barrier();
    n_checks++; if (iter_count !== ITER_W'(8)) begin n_fail++; $display("FAIL ign_next_count: got %0d expected 8", iter_count); end
  endtask

  task automatic test_reset_in_sort();
    repeat (31) barrier();
    barrier();
    n_checks++; if (sort_start !== 1'b1 || iter_count !== ITER_W'(40)) begin n_fail++; $display("FAIL rs_sort_entry: got ss=%b cnt=%0d expected 1 40", sort_start, iter_count); end
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (outs !== 7'b0 || iter_count !== '0) begin n_fail++; $display("FAIL rs_outs: got %b cnt=%0d expected 0000000 cnt=0", outs, iter_count); end
    sort_done = 1'b1; repeat (3) step(); sort_done = 1'b0;
    n_checks++; if (outs !== 7'b0) begin n_fail++; $display("FAIL rs_stay_idle: got %b expected 0000000", outs); end
  endtask

  task automatic test_max_iter_one();
    start1 = 1'b1; ant1 = 4'hF; sort_done1 = 1'b1; step(); start1 = 1'b0;
    n_checks++; if ({run_en1, sync_go1} !== 2'b10) begin n_fail++; $display("FAIL m1_run: got %b expected 10", {run_en1, sync_go1}); end
    step();
    n_checks++; if (sync_go1 !== 1'b1) begin n_fail++; $display("FAIL m1_go: got %b expected 1", sync_go1); end
    step();
    n_checks++; if ({sort_start1, run_en1, sync_go1, sort_en1} !== 4'b1001 || iter_count1 !== ITER_W'(1)) begin n_fail++; $display("FAIL m1_sort: got %b cnt=%0d expected 1001 cnt=1", {sort_start1, run_en1, sync_go1, sort_en1}, iter_count1); end
    step();
    n_checks++; if ({done1, sort_start1, busy1} !== 3'b100) begin n_fail++; $display("FAIL m1_early_sort_done: got %b expected 100", {done1, sort_start1, busy1}); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (sync_go1 !== 1'b0 || iter_count1 !== ITER_W'(1) || done1 !== 1'b1) begin n_fail++; $display("FAIL m1_no_second k=%0d: got go=%b cnt=%0d done=%b expected 0 1 1", k, sync_go1, iter_count1, done1); end
    end
    sort_done1 = 1'b0;
  endtask

`ifdef ITER_TIMEOUT_EN
  task automatic test_timeout();
    start = 1'b1; ant = 4'h7; step(); start = 1'b0;
    repeat (99) step();
    n_checks++; if ({run_en, timeout_err, sort_start} !== 3'b100) begin n_fail++; $display("FAIL to_before: got %b expected 100", {run_en, timeout_err, sort_start}); end
    step();
    n_checks++; if ({timeout_err, sort_start, run_en} !== 3'b110 || iter_count !== '0) begin n_fail++; $display("FAIL to_fire: got %b cnt=%0d expected 110 cnt=0", {timeout_err, sort_start, run_en}, iter_count); end
    sort_done = 1'b1; step(); sort_done = 1'b0;
    n_checks++; if ({done, timeout_err} !== 2'b11) begin n_fail++; $display("FAIL to_sticky: got %b expected 11", {done, timeout_err}); end
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if ({timeout_err, busy} !== 2'b01) begin n_fail++; $display("FAIL to_clear: got %b expected 01", {timeout_err, busy}); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_run();
    test_random_barrier();
    test_stale_sync();
    test_start_ignored();
    test_reset_in_sort();
    test_max_iter_one();
`ifdef ITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
